// File: rtl/rd_fwft_pkg.sv
// Purpose: shared constants and index/count types for the FWFT read stage.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package rd_fwft_pkg;

    // Number of output buffer entries; sized to cover the one-cycle RAM read latency
    localparam int BUF_DEPTH = 3;

    // Circular buffer index, wraps 2 -> 0
    typedef logic [1:0] idx_t;

    // Buffered word count, 0..BUF_DEPTH
    typedef logic [1:0] cnt_t;

    // Next circular index; the top index wraps back to entry 0
    function automatic idx_t idx_next(input idx_t idx);
        idx_t nxt;
        if (idx == idx_t'(BUF_DEPTH - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + idx_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rd_fwft_if.sv
// Purpose: valid/ready output stream of the FWFT stage, plus buffered-word count.
// Latency: n/a (wiring only).
// Backpressure: consumer holds m_ready low to stall; producer keeps m_valid/m_data stable.
interface rd_fwft_if
    import rd_fwft_pkg::*;
#(
    parameter int DSIZE = 8
) ();

    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    cnt_t             m_count;

    // Stream producer side (the FWFT stage)
    modport master (
        output m_valid,
        output m_data,
        output m_count,
        input  m_ready
    );

    // Stream consumer side
    modport slave (
        input  m_valid,
        input  m_data,
        input  m_count,
        output m_ready
    );

endinterface

// File: rtl/rd_fwft_buf.sv
// Purpose: 3-entry register storage with one write port and an asynchronous read mux.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller guarantees it never writes a live entry.
module rd_fwft_buf
    import rd_fwft_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             wr_en,
    input  idx_t             wr_idx,
    input  logic [DSIZE-1:0] wr_dat,
    input  idx_t             rd_idx,
    output logic [DSIZE-1:0] rd_dat
);

    logic [DSIZE-1:0] mem_q [BUF_DEPTH];
    logic [DSIZE-1:0] mem_d [BUF_DEPTH];

    // Next-state storage: only the addressed entry takes the incoming word
    always_comb begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_en && (wr_idx == idx_t'(i))) begin
                mem_d[i] = wr_dat;
            end
        end
    end

    // Data storage is deliberately not reset; validity is tracked by the count
    always_ff @(posedge rclk) begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // Asynchronous read of the head entry; the unused index 3 falls back to entry 0
    always_comb begin
        rd_dat = mem_q[0];
        case (rd_idx)
            2'd1:    rd_dat = mem_q[1];
            2'd2:    rd_dat = mem_q[2];
            default: rd_dat = mem_q[0];
        endcase
    end

endmodule

// File: rtl/rd_fwft_stage.sv
// Purpose: turns the FIFO's registered-read RAM port into a first-word-fall-through stream.
// Latency: rinc at cycle t -> word on m_data with m_valid=1 after edge t+1 (buffer empty).
// Backpressure: credit based; rinc only while count+inflight < 3, never from m_ready combinationally.
module rd_fwft_stage
    import rd_fwft_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    output logic             rinc,
    input  logic [DSIZE-1:0] rdata,
    rd_fwft_if.master        m_if
);

    cnt_t count_q,    count_d;
    logic inflight_q, inflight_d;
    idx_t wr_idx_q,   wr_idx_d;
    idx_t rd_idx_q,   rd_idx_d;

    logic             push;
    logic             pop;
    logic [2:0]       credit_use;
    logic [DSIZE-1:0] head_dat;

    // Words already owned by this stage: buffered plus the one on the RAM read port
    assign credit_use = {1'b0, count_q} + {2'b00, inflight_q};

    // Request a word only when it is readable and a buffer slot is guaranteed for it;
    // gated by reset so no pop escapes upstream while the pointer logic is being reset
    assign rinc = rrst_n && !rempty && (credit_use < 3'(BUF_DEPTH));

    // A word lands in the buffer the cycle after its request
    assign push = inflight_q;

    // Consumer pop; m_ready is ignored while nothing is buffered
    assign pop = (count_q != '0) && m_if.m_ready;

    // Next-state for count, in-flight flag and circular indices
    always_comb begin
        count_d    = count_q;
        inflight_d = rinc;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;

        if (push) begin
            wr_idx_d = idx_next(wr_idx_q);
        end
        if (pop) begin
            rd_idx_d = idx_next(rd_idx_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards buffered and in-flight words
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            count_q    <= '0;
            inflight_q <= 1'b0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
        end
    end

    rd_fwft_buf #(
        .DSIZE (DSIZE)
    ) u_buf (
        .rclk   (rclk),
        .wr_en  (push),
        .wr_idx (wr_idx_q),
        .wr_dat (rdata),
        .rd_idx (rd_idx_q),
        .rd_dat (head_dat)
    );

    assign m_if.m_valid = (count_q != '0);
    assign m_if.m_data  = head_dat;
    assign m_if.m_count = count_q;

    // The credit check must keep buffered plus in-flight words within the buffer depth
    a_no_overflow : assert property (@(posedge rclk) disable iff (!rrst_n)
        credit_use <= 3'(BUF_DEPTH));

    // No pop request may reach the pointer logic while it reports empty
    a_no_rinc_when_empty : assert property (@(posedge rclk) disable iff (!rrst_n)
        !(rinc && rempty));

endmodule

// File: tb/tb_rd_fwft_stage.sv
// Purpose: self-checking bench for rd_fwft_stage (vector table plus directed/random sequences).
// Latency: n/a.
// Backpressure: bench drives m_ready patterns and models the registered-read RAM upstream.
module tb_rd_fwft_stage;
    import rd_fwft_pkg::*;

    localparam int DSIZE = 8;

    logic             rclk = 1'b0;
    logic             rrst_n;
    logic             rempty;
    logic             rinc;
    logic [DSIZE-1:0] rdata;

    rd_fwft_if #(.DSIZE(DSIZE)) s_if ();

    rd_fwft_stage #(.DSIZE(DSIZE)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .rempty (rempty),
        .rinc   (rinc),
        .rdata  (rdata),
        .m_if   (s_if)
    );

    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DSIZE-1:0] ram [0:1023];
    int               rd_ptr;

    typedef struct {
        logic       rempty;
        logic       rdy;
        logic       exp_rinc;
        logic       exp_vld;
        logic [1:0] exp_cnt;
        logic [7:0] exp_dat;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Upstream RAM model: a word requested before this edge appears on rdata after it
    task automatic edge_step();
        logic r;
        r = rinc;
        @(posedge rclk);
        #1;
        if (r === 1'b1) begin
            rdata = ram[rd_ptr[9:0]];
            rd_ptr++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         pops;
        int         first_pop;
        int         last_pop;
        logic       held;
        logic [7:0] held_dat;
        logic       gap;

        rrst_n        = 1'b0;
        rempty        = 1'b1;
        rdata         = '0;
        s_if.m_ready  = 1'b0;
        rd_ptr        = 0;

        ram[0] = 8'hA5; ram[1] = 8'h5A; ram[2] = 8'h3C; ram[3] = 8'hC3; ram[4] = 8'h99;

        //            rempty rdy  rinc vld  cnt   dat
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'hA5};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'hA5};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'hA5};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'hA5};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'hA5};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 8'h5A};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 8'h5A};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 8'h3C};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 8'hC3};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 8'h99};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};

        // Reset state
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        chk("reset.m_valid", s_if.m_valid, 0);
        chk("reset.m_count", s_if.m_count, 0);
        chk("reset.rinc",    rinc,         0);
        rrst_n = 1'b1;

        // Single word, backpressure fill to 3, resume, drain
        for (int i = 0; i < 15; i++) begin
            rempty       = vecs[i].rempty;
            s_if.m_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d.rinc", i),    rinc,         vecs[i].exp_rinc);
            chk($sformatf("vec%0d.m_valid", i), s_if.m_valid, vecs[i].exp_vld);
            chk($sformatf("vec%0d.m_count", i), s_if.m_count, vecs[i].exp_cnt);
            if (vecs[i].exp_vld) begin
                chk($sformatf("vec%0d.m_data", i), s_if.m_data, vecs[i].exp_dat);
            end
            edge_step();
        end

        // Reset mid-stream with two words buffered and one in flight
        rd_ptr       = 0;
        rempty       = 1'b0;
        s_if.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            edge_step();
        end
        #1;
        chk("midrst.pre_count", s_if.m_count, 2);
        #2;
        rrst_n = 1'b0;
        rd_ptr = 0;
        #1;
        chk("midrst.m_valid", s_if.m_valid, 0);
        chk("midrst.m_count", s_if.m_count, 0);
        chk("midrst.rinc",    rinc,         0);
        for (int i = 0; i < 2; i++) begin
            edge_step();
            #1;
            chk($sformatf("midrst.rinc_hold%0d", i), rinc, 0);
            chk($sformatf("midrst.count_hold%0d", i), s_if.m_count, 0);
        end
        @(negedge rclk);
        rrst_n = 1'b1;
        #1;
        chk("midrst.rinc_after_release", rinc, 1);
        rempty = 1'b1;
        #1;
        chk("midrst.rinc_rempty", rinc, 0);
        edge_step();
        edge_step();
        #1;
        chk("midrst.discarded_valid", s_if.m_valid, 0);
        chk("midrst.discarded_count", s_if.m_count, 0);

        // Streaming 16 words with m_ready held high
        for (int i = 0; i < 16; i++) ram[i] = 8'(i);
        rd_ptr    = 0;
        pops      = 0;
        first_pop = -1;
        last_pop  = -1;
        for (int c = 0; c < 40; c++) begin
            rempty       = (rd_ptr >= 16);
            s_if.m_ready = 1'b1;
            #1;
            if (s_if.m_valid === 1'b1) begin
                chk($sformatf("stream.data%0d", pops), s_if.m_data, ram[pops]);
                if (first_pop < 0) first_pop = c;
                last_pop = c;
                pops++;
            end
            edge_step();
        end
        #1;
        chk("stream.pops",      pops,      16);
        chk("stream.first_pop", first_pop, 2);
        chk("stream.last_pop",  last_pop,  17);
        chk("stream.m_valid",   s_if.m_valid, 0);
        chk("stream.rinc",      rinc,      0);

        // Random m_ready and rempty gaps, 1000 words
        for (int i = 0; i < 1000; i++) ram[i] = 8'((i * 37 + 11) & 255);
        rd_ptr = 0;
        pops   = 0;
        held   = 1'b0;
        held_dat = '0;
        for (int c = 0; c < 20000 && pops < 1000; c++) begin
            gap          = ($urandom_range(0, 3) == 0);
            rempty       = (rd_ptr >= 1000) || gap;
            s_if.m_ready = $urandom_range(0, 1) == 1;
            #1;
            chk("rand.rinc_while_empty", rinc & rempty, 0);
            chk("rand.valid_vs_count", s_if.m_valid, (s_if.m_count != 0));
            if (held) begin
                chk("rand.hold_valid", s_if.m_valid, 1);
                chk("rand.hold_data",  s_if.m_data,  held_dat);
            end
            if (s_if.m_valid === 1'b1 && s_if.m_ready === 1'b1) begin
                chk($sformatf("rand.data%0d", pops), s_if.m_data, ram[pops]);
                pops++;
            end
            held     = (s_if.m_valid === 1'b1) && (s_if.m_ready === 1'b0);
            held_dat = s_if.m_data;
            edge_step();
        end
        chk("rand.pops_done", pops, 1000);

        // Drain: nothing left upstream, consumer ready
        rempty       = 1'b1;
        s_if.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            edge_step();
        end
        #1;
        chk("drain.m_valid", s_if.m_valid, 0);
        chk("drain.m_count", s_if.m_count, 0);
        chk("drain.rinc",    rinc,         0);
        chk("drain.no_extra_reads", rd_ptr, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
